// File: rtl/vec_mul_pkg.sv
// vec_mul_pkg: shared state type and constants for the vector multiply sequencer
package vec_mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} vm_state_t;
  localparam int DEF_VEC_LEN = 5;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W-1:0] Q_ONE = {1'b0, {(DEF_DATA_W-1){1'b1}}};
endpackage

// File: rtl/vec_mul_elem_pipe.sv
// vec_mul_elem_pipe: two-stage a*(b/Q_ONE) pipeline with stall control; VEC_MUL_SAT_EN saturates the product
module vec_mul_elem_pipe import vec_mul_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              last_i,
  input  logic              out_ready_i,
  output logic              hold_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);
  localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};
  logic              v1_q, pos1_q, neg1_q, last1_q, v2_q, last2_q;
  logic [DATA_W-1:0] a1_q, p2_q, neg_a, prod_d;
  logic              stall2, pos_d, neg_d;
`ifdef VEC_MUL_SAT_EN
  assign neg_a = (a1_q == MINV) ? MAXV : -a1_q;
`else
  assign neg_a = -a1_q;
`endif
  // Quotient decode (truncating b/MAXV is +1, -1 or 0), product select and stall
  always_comb begin
    stall2 = v2_q && !out_ready_i;
    hold_o = v1_q && stall2;
    pos_d  = b_i == MAXV;
    neg_d  = (b_i == -MAXV) || (b_i == MINV);
    prod_d = pos1_q ? a1_q : neg1_q ? neg_a : '0;
  end
  // Stage 1 holds only when stage 2 is stalled; stage 2 holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      pos1_q  <= 1'b0;
      neg1_q  <= 1'b0;
      last1_q <= 1'b0;
      a1_q    <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      p2_q    <= '0;
    end else begin
      if (!hold_o) begin
        v1_q    <= acc_i;
        pos1_q  <= pos_d;
        neg1_q  <= neg_d;
        last1_q <= acc_i && last_i;
        a1_q    <= a_i;
      end
      if (!stall2) begin
        v2_q    <= v1_q;
        last2_q <= last1_q;
        p2_q    <= prod_d;
      end
    end
  end
  assign out_valid_o = v2_q;
  assign out_data_o  = p2_q;
  assign out_last_o  = last2_q;
endmodule

// File: rtl/vec_mul_sequencer.sv
// vec_mul_sequencer: job FSM, element counter and last tagging around the multiply pipe; VEC_MUL_SAT_EN enables saturation
module vec_mul_sequencer import vec_mul_pkg::*; #(
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [$clog2(VEC_LEN+1)-1:0]   cfg_len_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [DATA_W-1:0]              in_a_i,
  input  logic [DATA_W-1:0]              in_b_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DATA_W-1:0]              out_data_o,
  output logic                           out_last_o,
  output logic                           busy_o,
  output logic                           done_o
);
  localparam int LW = $clog2(VEC_LEN+1);
  vm_state_t     state_q, state_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d, eff_len;
  logic          hold, acc, last_tag, launch, last_xfer;
  vec_mul_elem_pipe #(.DATA_W(DATA_W)) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .acc_i       (acc),
    .a_i         (in_a_i),
    .b_i         (in_b_i),
    .last_i      (last_tag),
    .out_ready_i (out_ready_i),
    .hold_o      (hold),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o)
  );
  // Next state, effective length, accept handshake and last tag
  always_comb begin
    eff_len    = (cfg_len_i == '0 || cfg_len_i > LW'(VEC_LEN)) ? LW'(VEC_LEN) : cfg_len_i;
    launch     = state_q == IDLE && start_i;
    in_ready_o = state_q == RUN && cnt_q < len_q && !hold;
    acc        = in_valid_i && in_ready_o;
    last_tag   = cnt_q == len_q - LW'(1);
    last_xfer  = out_valid_o && out_ready_i && out_last_o;
    state_d    = state_q == IDLE  ? (start_i ? RUN : IDLE) :
                 state_q == RUN   ? (cnt_q == len_q ? DRAIN : RUN) :
                 state_q == DRAIN ? (last_xfer ? DONE : DRAIN) : IDLE;
    len_d      = launch ? eff_len : len_q;
    cnt_d      = launch ? '0 : cnt_q + LW'(acc);
    busy_o     = state_q != IDLE;
    done_o     = state_q == DONE;
  end
  // State, length and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
